// File: rtl/ls20_self_test_ctrl.sv
// Self-test sequencer for a dual 4-input NAND part: sweeps all 16 vectors, counts output mismatches.
// Optional macro LS20_FIRST_FAIL_LOG_EN adds a first-mismatch log (fail_vec, fail_gate, fail_valid).
module ls20_self_test_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y1,
  input  logic       y2,
  output logic [3:0] vec1,
  output logic [3:0] vec2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_cnt,
`ifdef LS20_FIRST_FAIL_LOG_EN
  output logic [3:0] fail_vec,
  output logic       fail_gate,
  output logic       fail_valid,
`endif
  output logic [1:0] o_dbg_state
);

  // Handshake: start is a level request accepted only in IDLE; busy covers SETTLE/SAMPLE,
  // done pulses for exactly one cycle, and pass/err_cnt stay stable until the next accepted start.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_vec1;
  logic [7:0] r_cnt;
  logic [5:0] r_err;
  logic       r_pass;

  logic [3:0] w_vec2;
  logic       w_exp1;
  logic       w_exp2;
  logic       w_mis1;
  logic       w_mis2;
  logic [5:0] w_err_next;
  logic       w_accept;
  logic       w_last_vec;

  assign w_vec2     = ~r_vec1;
  assign w_exp1     = ~&r_vec1;
  assign w_exp2     = ~&w_vec2;
  assign w_mis1     = y1 ^ w_exp1;
  assign w_mis2     = y2 ^ w_exp2;
  assign w_err_next = r_err + {5'd0, w_mis1} + {5'd0, w_mis2};
  assign w_accept   = (r_state == IDLE) && start;
  assign w_last_vec = (r_vec1 == 4'hF);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = SETTLE;
      SETTLE:  if (r_cnt == LP_LAST) w_state_next = SAMPLE;
      SAMPLE:  w_state_next = w_last_vec ? DONE : SETTLE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // The final SAMPLE folds its own mismatches into pass, so pass is valid during the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec1 <= 4'd0;
      r_cnt  <= 8'd0;
      r_err  <= 6'd0;
      r_pass <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_vec1 <= 4'd0;
            r_cnt  <= 8'd0;
            r_err  <= 6'd0;
            r_pass <= 1'b0;
          end
        end
        SETTLE: begin
          r_cnt <= r_cnt + 8'd1;
        end
        SAMPLE: begin
          r_err <= w_err_next;
          if (w_last_vec) begin
            r_pass <= (w_err_next == 6'd0);
          end else begin
            r_vec1 <= r_vec1 + 4'd1;
            r_cnt  <= 8'd0;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef LS20_FIRST_FAIL_LOG_EN
  logic [3:0] r_fail_vec;
  logic       r_fail_gate;
  logic       r_fail_valid;

  // Gate 1 wins a simultaneous mismatch, so the gate flag is simply "gate 1 was fine".
  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_fail_vec   <= 4'd0;
      r_fail_gate  <= 1'b0;
      r_fail_valid <= 1'b0;
    end else if ((r_state == SAMPLE) && (w_mis1 || w_mis2) && !r_fail_valid) begin
      r_fail_vec   <= r_vec1;
      r_fail_gate  <= ~w_mis1;
      r_fail_valid <= 1'b1;
    end
  end

  assign fail_vec   = r_fail_vec;
  assign fail_gate  = r_fail_gate;
  assign fail_valid = r_fail_valid;
`endif

  assign vec1        = r_vec1;
  assign vec2        = w_vec2;
  assign busy        = (r_state == SETTLE) || (r_state == SAMPLE);
  assign done        = (r_state == DONE);
  assign pass        = r_pass;
  assign err_cnt     = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ls20_self_test_ctrl.sv
// Directed bench for ls20_self_test_ctrl: NAND device model with stuck-at faults, scoreboard of run results.
module tb_ls20_self_test_ctrl;

  localparam int S0 = 4;
  localparam int S1 = 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst    = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;

  logic [3:0] vec1_0, vec2_0, vec1_1, vec2_1;
  logic       busy_0, done_0, pass_0, busy_1, done_1, pass_1;
  logic [5:0] err_0, err_1;
  logic [1:0] st_0, st_1;
  logic       y1_0, y2_0, y1_1, y2_1;
  logic       n1_0, n2_0, n1_1, n2_1;
`ifdef LS20_FIRST_FAIL_LOG_EN
  logic [3:0] fvec_0, fvec_1;
  logic       fgate_0, fgate_1, fval_0, fval_1;
`endif

  // fault mode per gate: 0 = healthy, 1 = stuck at 0, 2 = stuck at 1
  int f1 = 0;
  int f2 = 0;

  assign #10 n1_0 = ~&vec1_0;
  assign #10 n2_0 = ~&vec2_0;
  assign #10 n1_1 = ~&vec1_1;
  assign #10 n2_1 = ~&vec2_1;
  assign y1_0 = (f1 == 0) ? n1_0 : (f1 == 2);
  assign y2_0 = (f2 == 0) ? n2_0 : (f2 == 2);
  assign y1_1 = (f1 == 0) ? n1_1 : (f1 == 2);
  assign y2_1 = (f2 == 0) ? n2_1 : (f2 == 2);

  ls20_self_test_ctrl #(.SETTLE_CYCLES(S0)) dut (
    .clk(clk), .rst(rst), .start(start0), .y1(y1_0), .y2(y2_0),
    .vec1(vec1_0), .vec2(vec2_0), .busy(busy_0), .done(done_0), .pass(pass_0),
    .err_cnt(err_0),
`ifdef LS20_FIRST_FAIL_LOG_EN
    .fail_vec(fvec_0), .fail_gate(fgate_0), .fail_valid(fval_0),
`endif
    .o_dbg_state(st_0)
  );

  ls20_self_test_ctrl #(.SETTLE_CYCLES(S1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .y1(y1_1), .y2(y2_1),
    .vec1(vec1_1), .vec2(vec2_1), .busy(busy_1), .done(done_1), .pass(pass_1),
    .err_cnt(err_1),
`ifdef LS20_FIRST_FAIL_LOG_EN
    .fail_vec(fvec_1), .fail_gate(fgate_1), .fail_valid(fval_1),
`endif
    .o_dbg_state(st_1)
  );

  // observed signals of the selected instance
  logic       sel = 1'b0;
  logic [3:0] w_vec1, w_vec2;
  logic       w_busy, w_done, w_pass;
  logic [5:0] w_err;
  logic [1:0] w_st;
  assign w_vec1 = sel ? vec1_1 : vec1_0;
  assign w_vec2 = sel ? vec2_1 : vec2_0;
  assign w_busy = sel ? busy_1 : busy_0;
  assign w_done = sel ? done_1 : done_0;
  assign w_pass = sel ? pass_1 : pass_0;
  assign w_err  = sel ? err_1  : err_0;
  assign w_st   = sel ? st_1   : st_0;
`ifdef LS20_FIRST_FAIL_LOG_EN
  logic [3:0] w_fvec;
  logic       w_fgate, w_fval;
  assign w_fvec  = sel ? fvec_1  : fvec_0;
  assign w_fgate = sel ? fgate_1 : fgate_0;
  assign w_fval  = sel ? fval_1  : fval_0;
`endif

  // scoreboard: {fail_valid, fail_gate, fail_vec[3:0], pass, err_cnt[5:0]}
  logic [12:0] exp_q[$];
  logic [12:0] last_exp;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start1 = v;
    else start0 = v;
  endtask

  // reference: NAND truth table against the injected faults over the full sweep
  task automatic model(input int m1, input int m2, output int err, output int fv,
                       output int fg, output int fval);
    logic [3:0] a, b;
    logic e1, e2, o1, o2;
    err = 0; fv = 0; fg = 0; fval = 0;
    for (int v = 0; v < 16; v++) begin
      a  = v[3:0];
      b  = ~a;
      e1 = ~(a[0] & a[1] & a[2] & a[3]);
      e2 = ~(b[0] & b[1] & b[2] & b[3]);
      o1 = (m1 == 0) ? e1 : (m1 == 2);
      o2 = (m2 == 0) ? e2 : (m2 == 2);
      if (o1 != e1) err++;
      if (o2 != e2) err++;
      if (fval == 0 && (o1 != e1 || o2 != e2)) begin
        fval = 1;
        fv   = v;
        fg   = (o1 != e1) ? 0 : 1;
      end
    end
  endtask

  task automatic launch(input int m1, input int m2);
    int e, fv, fg, fval;
    f1 = m1;
    f2 = m2;
    model(m1, m2, e, fv, fg, fval);
    exp_q.push_back({fval[0], fg[0], fv[3:0], (e == 0), e[5:0]});
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_vec1"}, w_vec1, 0);
    chk({tag, "_vec2"}, w_vec2, 15);
    chk({tag, "_busy"}, w_busy, 0);
    chk({tag, "_done"}, w_done, 0);
    chk({tag, "_pass"}, w_pass, 0);
    chk({tag, "_err"}, w_err, 0);
    chk({tag, "_state"}, w_st, 0);
`ifdef LS20_FIRST_FAIL_LOG_EN
    chk({tag, "_fval"}, w_fval, 0);
`endif
  endtask

  // Drives a start at the current negedge and follows the run to its done pulse.
  task automatic observe(input string tag, input int exp_lat, input int dist_at);
    int n = 1;
    int busy_n = 0;
    int comp_bad = 0;
    logic [12:0] e;
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    while (w_done !== 1'b1 && n < 400) begin
      if (w_busy === 1'b1) busy_n++;
      if (w_vec2 !== ~w_vec1) comp_bad++;
      set_start(n == dist_at);
      @(negedge clk);
      n++;
    end
    set_start(1'b0);
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_busy_cycles"}, busy_n, exp_lat - 1);
    chk({tag, "_vec2_compl"}, comp_bad, 0);
    chk({tag, "_done"}, w_done, 1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    last_exp = e;
    chk({tag, "_err"}, w_err, e[5:0]);
    chk({tag, "_pass"}, w_pass, e[6]);
`ifdef LS20_FIRST_FAIL_LOG_EN
    chk({tag, "_fval"}, w_fval, e[12]);
    if (e[12]) begin
      chk({tag, "_fvec"}, w_fvec, e[10:7]);
      chk({tag, "_fgate"}, w_fgate, e[11]);
    end
`endif
    @(negedge clk);
    chk({tag, "_done_pulse"}, w_done, 0);
    chk({tag, "_back_idle"}, w_st, 0);
  endtask

  initial begin
    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    sel = 1'b0;
    check_reset_state("rst0");
    sel = 1'b1;
    check_reset_state("rst1");
    sel = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // healthy device
    launch(0, 0);
    observe("good", 16 * (S0 + 1) + 1, 0);

    // idle holds result and last vector
    repeat (5) @(negedge clk);
    chk("idle_err", w_err, last_exp[5:0]);
    chk("idle_pass", w_pass, last_exp[6]);
    chk("idle_vec1", w_vec1, 15);
    chk("idle_busy", w_busy, 0);

    // stuck-at faults
    launch(2, 0);
    observe("y1_sa1", 16 * (S0 + 1) + 1, 0);
    launch(0, 1);
    observe("y2_sa0", 16 * (S0 + 1) + 1, 0);
    launch(1, 2);
    observe("both_fail", 16 * (S0 + 1) + 1, 0);
    for (int i = 0; i < 3; i++) begin
      launch(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      observe("rand", 16 * (S0 + 1) + 1, 0);
    end

    // second start mid-run is ignored
    launch(0, 0);
    observe("restart_ign", 16 * (S0 + 1) + 1, 20);

    // reset mid-run, then a full healthy run
    f1 = 0;
    f2 = 1;
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    repeat (29) @(negedge clk);
    chk("midrun_busy", w_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("midrun_rst");
    launch(0, 0);
    observe("after_rst", 16 * (S0 + 1) + 1, 0);

    // reset wins over start on the same edge
    rst = 1'b1;
    set_start(1'b1);
    @(negedge clk);
    rst = 1'b0;
    set_start(1'b0);
    check_reset_state("rst_prio");
    @(negedge clk);
    chk("rst_prio_idle", w_st, 0);

    // minimum settle time
    sel = 1'b1;
    launch(0, 0);
    observe("settle1", 16 * (S1 + 1) + 1, 0);
    sel = 1'b0;

    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ls20_self_test_ctrl.md
LS20_SELF_TEST_CTRL -- requirements
Module: ls20_self_test_ctrl

Interface
REQ-001 The block SHALL provide parameter SETTLE_CYCLES, default 4, giving clock cycles (legal 1..255) that each vector is held before its outputs are sampled.
REQ-002 The block SHALL provide port clk, input, 1, the single clock; all logic rises on posedge clk.
REQ-003 The block SHALL provide port rst, input, 1, the reset: synchronous and active-high.
REQ-004 The block SHALL provide port start, input, 1, a request to begin a test run, sampled only in IDLE.
REQ-005 The block SHALL provide port y1, input, 1, the gate-1 NAND output from the device under test.
REQ-006 The block SHALL provide port y2, input, 1, the gate-2 NAND output from the device under test.
REQ-007 The block SHALL provide port vec1, output, 4, gate-1 drive {a1,b1,c1,d1}.
REQ-008 The block SHALL provide port vec2, output, 4, gate-2 drive {a2,b2,c2,d2}.
REQ-009 The block SHALL provide port busy, output, 1, high in SETTLE and SAMPLE.
REQ-010 The block SHALL provide port done, output, 1, a one-cycle pulse at the end of a run.
REQ-011 The block SHALL provide port pass, output, 1, the result of the last run, held until the next start.
REQ-012 The block SHALL provide port err_cnt, output, 6, the mismatch count of the current or last run (0..32).

Function
REQ-013 The FSM SHALL have states IDLE, SETTLE, SAMPLE and DONE.
REQ-014 In IDLE with start=1, the next state SHALL be SETTLE, with vec1<=0, err_cnt<=0, pass<=0 and the settle counter cleared.
REQ-015 vec2 SHALL equal ~vec1 at all times, so gate 2 sees the complementary sweep.
REQ-016 In SETTLE the settle counter SHALL increment each cycle; at count SETTLE_CYCLES-1 the next state SHALL be SAMPLE.
REQ-017 SAMPLE SHALL last one cycle and compare y1 against ~&vec1 and y2 against ~&vec2.
REQ-018 In SAMPLE, err_cnt SHALL add 0, 1 or 2 according to the number of mismatches.
REQ-019 In SAMPLE with vec1!=15, the block SHALL increment vec1, clear the settle counter and return to SETTLE; with vec1==15 the next state SHALL be DONE.
REQ-020 DONE SHALL last one cycle with done=1 and pass set to 1 only if the final err_cnt (including the last SAMPLE) is 0; the next state SHALL be IDLE.
REQ-021 Latency: done SHALL be high in the cycle 16*(SETTLE_CYCLES+1)+1 cycles after the edge that samples start (81 cycles at the default).
REQ-022 start SHALL be ignored in SETTLE, SAMPLE and DONE; no restart and no counter disturbance.
REQ-023 In IDLE, vec1 SHALL hold its last value and err_cnt and pass SHALL hold the last result.
REQ-024 err_cnt SHALL NOT wrap; the maximum of 32 is representable.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, vec1=0, settle counter 0, busy=0, done=0, pass=0, err_cnt=0, from any state including mid-run.
REQ-026 rst SHALL take priority over start on the same edge.

Configuration
REQ-027 With macro LS20_FIRST_FAIL_LOG_EN defined, the block SHALL add output ports fail_vec (4) and fail_gate (1, 0=gate 1, 1=gate 2), plus fail_valid (1).
REQ-028 With LS20_FIRST_FAIL_LOG_EN defined, the block SHALL capture vec1 and the gate of the first mismatch of a run, with gate 1 winning if both gates mismatch together.
REQ-029 With LS20_FIRST_FAIL_LOG_EN defined, the fail_* outputs SHALL be cleared on rst and on an accepted start.
REQ-030 Without LS20_FIRST_FAIL_LOG_EN, the fail_* ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 Correct NAND model (10 ns gate delay, 10 ns clock, SETTLE_CYCLES=4), start pulse -> done at +81 cycles, pass=1, err_cnt=0, busy high for 80 cycles.
REQ-032 y1 stuck at 1 -> err_cnt=1, pass=0; with the macro, fail_vec=15, fail_gate=0, fail_valid=1.
REQ-033 y2 stuck at 0 -> err_cnt=15, pass=0; with the macro, fail_vec=1, fail_gate=1.
REQ-034 Second start pulse 20 cycles into a run -> ignored, done still at +81 from the first start, err_cnt unchanged.
REQ-035 rst asserted 30 cycles into a run -> next cycle IDLE with all outputs 0; a following start runs the full 81 cycles with pass=1.
REQ-036 SETTLE_CYCLES=1 with the correct model -> done at +33 cycles, pass=1.
